ram_pipe_model: RTL and testbench

// - Parametrised single-port RAM model with valid/ready request channel, configurable read latency and a

---
 rtl/ram_pipe_model.sv | 159 +++++++++++++++
 tb/tb_ram_pipe_model.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_pipe_model.sv
// Single-port RAM model: valid/ready requests, LAT-stage read pipeline, credit-limited response FIFO.
// Optional byte-masked writes when RAM_MASK_EN is defined.
module ram_pipe_model #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 32,
  parameter int LAT        = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [WIDTH-1:0]     req_wdata_i,
  input  logic [WIDTH/8-1:0]   req_wmask_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [WIDTH-1:0]     resp_rdata_o,
  output logic                 resp_err_o
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CREDITS   = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RESP_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAT_GUARD(p)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] PTR_LAT_GUARD(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? p : PTR_LAST;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [LAT-1:0]   pipe_vld_q;
  logic [LAT-1:0]   pipe_err_q;
  logic [WIDTH-1:0] pipe_data_q [LAT];

  logic [WIDTH-1:0] fifo_data_q [RESP_DEPTH];
  logic             fifo_err_q  [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, outs_q, outs_d;

  logic             in_range_s, accept_s, rd_acc_s, wr_acc_s, push_s, pop_s;
  logic [IDX_W-1:0] idx_s;
  logic [WIDTH-1:0] rd_word_s;

`ifndef RAM_MASK_EN
  logic unused_wmask_s;
  assign unused_wmask_s = ^req_wmask_i;
`endif

  assign in_range_s   = {1'b0, req_addr_i} < DEPTH_EXT;
  assign idx_s        = req_addr_i[IDX_W-1:0];
  assign req_ready_o  = outs_q < CREDITS;
  assign accept_s     = req_valid_i && req_ready_o && !reset_i;
  assign rd_acc_s     = accept_s && !req_we_i;
  assign wr_acc_s     = accept_s && req_we_i && in_range_s;
  assign push_s       = pipe_vld_q[LAT-1];
  assign resp_valid_o = count_q != '0;
  assign pop_s        = resp_valid_o && resp_ready_i;
  assign resp_rdata_o = resp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_err_o   = resp_valid_o ? fifo_err_q[rd_ptr_q] : 1'b0;

  always_comb begin
    rd_word_s = '0;
    if (in_range_s) begin
      rd_word_s = mem_q[idx_s];
    end else begin
      rd_word_s = '0;
    end
  end

  // Storage is never reset; out-of-range writes are dropped by wr_acc_s.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
`ifdef RAM_MASK_EN
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (req_wmask_i[b]) begin
          mem_q[idx_s][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end
`else
      mem_q[idx_s] <= req_wdata_i;
`endif
    end
  end

  always_comb begin
    outs_d   = outs_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rd_acc_s && !pop_s) begin
      outs_d = outs_q + CNT_W'(1);
    end else if (!rd_acc_s && pop_s) begin
      outs_d = outs_q - CNT_W'(1);
    end else begin
      outs_d = outs_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outs_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_vld_q <= '0;
    end else begin
      outs_q        <= outs_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pipe_vld_q[0] <= rd_acc_s;
      for (int k = 1; k < LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
      end
    end
  end

  // Payload only matters where the matching valid bit is set, so it shifts freely.
  always_ff @(posedge clk_i) begin
    pipe_data_q[0] <= rd_word_s;
    pipe_err_q[0]  <= !in_range_s;
    for (int k = 1; k < LAT; k++) begin
      pipe_data_q[k] <= pipe_data_q[k-1];
      pipe_err_q[k]  <= pipe_err_q[k-1];
    end
    if (push_s) begin
      fifo_data_q[wr_ptr_q] <= pipe_data_q[LAT-1];
      fifo_err_q[wr_ptr_q]  <= pipe_err_q[LAT-1];
    end
  end

endmodule

// File: tb/tb_ram_pipe_model.sv
// Directed bench for ram_pipe_model: vector table plus latency, back-pressure, reset and streaming sequences.
module tb_ram_pipe_model;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_pipe_model dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

`ifdef RAM_MASK_EN
  localparam logic [31:0] EXP_MASK3 = 32'hFF00FF00;
  localparam logic [31:0] EXP_MASK7 = 32'h11223344;
`else
  localparam logic [31:0] EXP_MASK3 = 32'h00000000;
  localparam logic [31:0] EXP_MASK7 = 32'hFFFFFFFF;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues one read, waits (bounded) for its response and checks it.
  task automatic read_check(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
    int t;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    step();
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 10) begin
      step();
      t++;
    end
    check({name, "_valid"}, 32'(resp_valid), 32'd1);
    check({name, "_rdata"}, resp_rdata, exp_data);
    check({name, "_err"}, 32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, seen, got, first, last;
    logic [31:0] bp_addr [4];

    vecs[0]  = '{1'b1, 32'd0,          32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'd3,          32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'd3,          32'h00000000, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'd3,          32'h0,        4'h0, EXP_MASK3,    1'b0};
    vecs[4]  = '{1'b1, 32'd7,          32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'd7,          32'h0,        4'h0, EXP_MASK7,    1'b0};
    vecs[7]  = '{1'b0, 32'd1024,       32'h0,        4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'd1024,       32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'd0,          32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 32'd1023,       32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'd1023,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFFFFFF,   32'h0,        4'h0, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'd5,          32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[14] = '{1'b1, 32'd1029,       32'h0BAD0BAD, 4'hF, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'd5,          32'h0,        4'h0, 32'hDEADBEEF, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
    step(); step(); step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    step();

    // Write then read-after-write with exact latency.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'hDEADBEEF; req_wmask = 4'hF;
    step();
    req_we = 1'b0;
    step();
    req_valid = 1'b0;
    check("lat_edge_n", 32'(resp_valid), 32'd0);
    step();
    check("lat_edge_n1", 32'(resp_valid), 32'd0);
    step();
    check("lat_edge_n2_valid", 32'(resp_valid), 32'd1);
    check("lat_edge_n2_rdata", resp_rdata, 32'hDEADBEEF);
    check("lat_edge_n2_err", 32'(resp_err), 32'd0);
    step();
    check("lat_popped", 32'(resp_valid), 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = vecs[i].addr;
        req_wdata = vecs[i].wdata; req_wmask = vecs[i].wmask;
        step();
        req_valid = 1'b0;
      end else begin
        read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err);
        step();
      end
    end

    // Back-pressure: credits limit outstanding reads.
    bp_addr[0] = 32'd5; bp_addr[1] = 32'd0; bp_addr[2] = 32'd1023; bp_addr[3] = 32'd7;
    resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_we = 1'b0;
      req_addr = bp_addr[(acc < 4) ? acc : 0];
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_req_ready_low", 32'(req_ready), 32'd0);
    check("bp_head_valid", 32'(resp_valid), 32'd1);
    check("bp_head_rdata", resp_rdata, 32'hDEADBEEF);
    step();
    check("bp_head_hold", resp_rdata, 32'hDEADBEEF);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_credit_return", 32'(req_ready), 32'd1);
    check("bp_next_head", resp_rdata, 32'hA5A5A5A5);
    resp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) seen++;
      step();
    end
    check("bp_drained", 32'(seen), 32'd3);

    // Reset with two reads in flight.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5;
    step();
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) seen++;
      step();
    end
    check("rst_mid_no_resp", 32'(seen), 32'd0);
    read_check("rst_mid_mem", 32'd5, 32'hDEADBEEF, 1'b0);
    step();

    // Streaming reads 0..7.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'(i);
      req_wdata = 32'h100 + 32'(i); req_wmask = 4'hF;
      step();
    end
    req_valid = 1'b0;
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        check($sformatf("stream%0d", got), resp_rdata, 32'h100 + 32'(got));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 8) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'(c);
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    check("stream_count", 32'(got), 32'd8);
    check("stream_consecutive", 32'(last - first), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
